m_fetch_queue: RTL

Instruction fetch front-end sitting directly upstream of the five-stage pipeline's IF/ID boundary. It issues sequential instruction-memory requests, buffers returned words with their PCs in a DEPTH-entry FIFO, and presents the head entry to decode. On a branch-miss redirect it discards buffered words and in-flight responses and restarts fetch at the target. Decode-side stalls (load-use) are absorbed by withholding dequeue.

---
 rtl/m_fetch_queue.sv | 111 +++++++++++
 1 files changed

// File: rtl/m_fetch_queue.sv
// m_fetch_queue: sequential instruction fetch with a credit-limited {pc, ir} FIFO
// feeding decode; a branch-miss redirect flushes the FIFO and drops in-flight responses.
`default_nettype none

module m_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_redir,
  input  logic [31:0] w_redir_pc,
  input  logic        w_deq,
  output logic        w_valid,
  output logic [31:0] w_ir,
  output logic [31:0] w_pc,
  output logic        w_mreq,
  output logic [31:0] w_maddr,
  input  logic        w_mack,
  input  logic        w_mrvalid,
  input  logic [31:0] w_mrdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] c_credit_max = (CW + 1)'(DEPTH);
  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic [31:0]   r_fpc;
  logic [31:0]   r_rpc;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_infl;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_pc_mem [DEPTH];
  logic [31:0]   r_ir_mem [DEPTH];

  logic          w_resp;
  logic          w_hs;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_credit;
  logic [CW-1:0] w_infl_after_resp;
  logic [31:0]   w_redir_tgt;

  // A response with nothing outstanding is a protocol error and is ignored entirely.
  assign w_resp            = w_mrvalid && (r_infl != '0);
  assign w_infl_after_resp = r_infl - CW'(w_resp);
  assign w_credit          = {1'b0, r_cnt} + {1'b0, r_infl};
  assign w_mreq            = !w_redir && !w_rst && (w_credit < c_credit_max);
  assign w_maddr           = r_fpc;
  assign w_hs              = w_mreq && w_mack;
  assign w_push            = w_resp && !w_redir && (r_drop == '0);
  assign w_pop             = w_deq && w_valid && !w_redir;
  assign w_redir_tgt       = w_redir_pc & ~32'h3;

  assign w_valid = (r_cnt != '0);
  assign w_ir    = w_valid ? r_ir_mem[r_rd] : c_nop;
  assign w_pc    = w_valid ? r_pc_mem[r_rd] : 32'h0;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_fpc  <= RESET_PC;
      r_rpc  <= RESET_PC;
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_infl <= '0;
      r_drop <= '0;
    end else if (w_redir) begin
      // Everything still outstanding (minus a response landing now) becomes stale.
      r_fpc  <= w_redir_tgt;
      r_rpc  <= w_redir_tgt;
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_infl <= w_infl_after_resp;
      r_drop <= w_infl_after_resp;
    end else begin
      if (w_hs) begin
        r_fpc <= r_fpc + 32'd4;
      end
      r_infl <= w_infl_after_resp + CW'(w_hs);
      if (w_resp) begin
        if (r_drop != '0) begin
          r_drop <= r_drop - CW'(1);
        end else begin
          r_rpc <= r_rpc + 32'd4;
        end
      end
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_push) begin
      r_pc_mem[r_wr] <= r_rpc;
      r_ir_mem[r_wr] <= w_mrdata;
    end
  end

endmodule

`default_nettype wire
